// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with a 2-flop input synchronizer.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx_byte #(
  parameter int BAUD_DIV = 868,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rbyte_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_END  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_END = CW'(HALF_DIV - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] AFTER_DATA = PARITY;
`else
  localparam logic [2:0] AFTER_DATA = STOP;
`endif

  logic          rx_q1;
  logic          rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sr;
`ifdef UART_RX_PARITY_EN
  logic          par_ok;
`endif

  assign busy = (state != IDLE);

  // Two-flop synchronizer; idles high so reset looks like a quiet line
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rxs   <= rx_q1;
    end
  end

  // Frame FSM: sample mid-bit, deliver the byte at the stop-bit sample
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      sr          <= '0;
      rx_byte     <= '0;
      rbyte_ready <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_ok      <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      rbyte_ready <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rxs) state <= START;
        end
        START: begin
          if (cnt == HALF_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            cnt     <= '0;
            sr      <= {rxs, sr[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= AFTER_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == BIT_END) begin
            cnt    <= '0;
            par_ok <= ~(^sr ^ rxs);
            state  <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rxs) begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_ok) begin
                rx_byte     <= sr;
                rbyte_ready <= 1'b1;
                frame_err   <= 1'b0;
              end else begin
                parity_err  <= 1'b1;
              end
`else
              rx_byte     <= sr;
              rbyte_ready <= 1'b1;
              frame_err   <= 1'b0;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          cnt <= '0;
          if (rxs) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed, table-driven and random frames for uart_rx_byte.
// Expected results come from frame-level rules, not from the receiver's FSM.
module tb_uart_rx_byte;

  localparam int BAUD = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NBITS   = PAR_EN ? 11 : 10;
  localparam int FRAME   = NBITS * BAUD;
  localparam int LAT_NOM = 2 + BAUD / 2 + (NBITS - 1) * BAUD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_byte;
  logic       rbyte_ready;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  uart_rx_byte #(.BAUD_DIV(BAUD)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .rx_byte(rx_byte),
    .rbyte_ready(rbyte_ready),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int n_ready = 0;
  int n_perr = 0;
  int last_pulse = 0;
  int frame_start = 0;
  bit busy_seen = 1'b0;
  logic prev_ready = 1'b0;

  logic [7:0] m_byte;
  bit         m_ferr;

  typedef struct packed {
    logic [7:0] d;
    logic       stop;
    logic [1:0] gap;
    logic       ready;
    logic [7:0] b;
    logic       ferr;
  } vec_t;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (rbyte_ready) begin
      n_ready++;
      last_pulse = cyc;
      checks++;
      if (prev_ready || parity_err) begin
        fails++;
        $display("FAIL pulse_shape: prev=%b perr=%b, required 0 0",
                 prev_ready, parity_err);
      end
    end
    if (parity_err) n_perr++;
    prev_ready = rbyte_ready;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    n_ready = 0;
    n_perr = 0;
    busy_seen = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic pflip);
    clear_mon();
    frame_start = cyc;
    hold(1'b0, BAUD);
    for (int i = 0; i < 8; i++) hold(d[i], BAUD);
    if (PAR_EN) hold(^d ^ pflip, BAUD);
    hold(stop, BAUD);
  endtask

  task automatic expect_frame(input string name, input int rdy,
                              input logic [7:0] b, input logic fe,
                              input int pe);
    int lat;
    check({name, "_ready"}, n_ready, rdy);
    check({name, "_byte"}, rx_byte, b);
    check({name, "_ferr"}, frame_err, fe);
    check({name, "_perr"}, n_perr, pe);
    if (rdy == 1) begin
      lat = last_pulse - frame_start;
      check({name, "_lat"}, (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 1);
    end
  endtask

  initial begin
    vec_t tbl[7];
    int p1;
    logic [7:0] d;
    logic st, pf;
    bit good;
    int gap;

    tbl = '{
      '{8'h00, 1'b1, 2'd1, 1'b1, 8'h00, 1'b0},
      '{8'hFF, 1'b1, 2'd0, 1'b1, 8'hFF, 1'b0},
      '{8'h80, 1'b0, 2'd1, 1'b0, 8'hFF, 1'b1},
      '{8'h01, 1'b1, 2'd0, 1'b1, 8'h01, 1'b0},
      '{8'hA5, 1'b1, 2'd2, 1'b1, 8'hA5, 1'b0},
      '{8'h5A, 1'b0, 2'd1, 1'b0, 8'hA5, 1'b1},
      '{8'h5A, 1'b1, 2'd0, 1'b1, 8'h5A, 1'b0}
    };

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    clear_mon();
    hold(1'b1, 200);
    check("rst_byte", rx_byte, 8'h00);
    check("rst_ready", n_ready, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", n_perr, 0);
    check("rst_busy", busy_seen, 0);

    send_frame(8'h2A, 1'b1, 1'b0);
    expect_frame("b2b_first", 1, 8'h2A, 1'b0, 0);
    p1 = last_pulse;
    send_frame(8'h2D, 1'b1, 1'b0);
    expect_frame("b2b_second", 1, 8'h2D, 1'b0, 0);
    check("b2b_spacing", last_pulse - p1, FRAME);
    hold(1'b1, BAUD);

    clear_mon();
    hold(1'b0, 5);
    hold(1'b1, 3 * BAUD);
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_now", busy, 0);
    check("glitch_ready", n_ready, 0);
    check("glitch_ferr", frame_err, 0);

    send_frame(8'h55, 1'b0, 1'b0);
    expect_frame("badstop", 0, 8'h2D, 1'b1, 0);
    hold(1'b0, 100);
    check("break_ready", n_ready, 0);
    check("break_busy", busy, 1);
    check("break_ferr", frame_err, 1);
    hold(1'b1, 2 * BAUD);
    send_frame(8'h41, 1'b1, 1'b0);
    expect_frame("after_break", 1, 8'h41, 1'b0, 0);
    hold(1'b1, BAUD);

    clear_mon();
    hold(1'b0, BAUD);
    hold(1'b0, 3 * BAUD);
    hold(1'b1, BAUD / 2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("midrst_byte", rx_byte, 8'h00);
    check("midrst_ready", rbyte_ready, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_busy", busy, 0);
    hold(1'b1, BAUD / 2 + 7 * BAUD);
    check("midrst_nopulse", n_ready, 0);
    send_frame(8'h2A, 1'b1, 1'b0);
    expect_frame("midrst_clean", 1, 8'h2A, 1'b0, 0);
    hold(1'b1, BAUD);

    foreach (tbl[i]) begin
      send_frame(tbl[i].d, tbl[i].stop, 1'b0);
      expect_frame($sformatf("tbl%0d", i), int'(tbl[i].ready), tbl[i].b,
                   tbl[i].ferr, 0);
      hold(1'b1, int'(tbl[i].gap) * BAUD);
    end
    m_byte = tbl[6].b;
    m_ferr = tbl[6].ferr;

`ifdef UART_RX_PARITY_EN
    send_frame(8'h2A, 1'b1, 1'b0);
    expect_frame("par_good", 1, 8'h2A, 1'b0, 0);
    send_frame(8'h2A, 1'b1, 1'b1);
    expect_frame("par_bad", 0, 8'h2A, 1'b0, 1);
    hold(1'b1, BAUD);
    m_byte = 8'h2A;
    m_ferr = 1'b0;
`endif

    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom);
      st  = ($urandom_range(0, 5) != 0);
      pf  = ($urandom_range(0, 3) == 0);
      gap = st ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, st, pf);
      good = st && !(PAR_EN && pf);
      if (good) begin
        m_byte = d;
        m_ferr = 1'b0;
      end else if (!st) begin
        m_ferr = 1'b1;
      end
      expect_frame($sformatf("rnd%0d", n), good ? 1 : 0, m_byte, m_ferr,
                   (st && PAR_EN && pf) ? 1 : 0);
      hold(1'b1, gap * BAUD);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Asynchronous serial receiver that sits directly upstream of the seed loader.
- Converts the board's RS-232 RX line into parallel bytes plus a ready strobe; the loader consumes these as '*' (live) and '-' (dead) cell characters.
- Fixed 8 data bits, LSB first, 1 stop bit; even parity is optional.
- Single clock domain; the RX pin is asynchronous and is synchronized internally.

Parameters:
- BAUD_DIV, 868, clk cycles per bit (100 MHz / 115200); legal range >= 4.
- HALF_DIV, BAUD_DIV/2, cycles from the start-bit falling edge to the start-bit mid-sample.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx  in  1  serial line; idle high; asynchronous to clk
- rx_byte  out  8  last correctly received byte; held stable until the next good byte
- rbyte_ready  out  1  one-cycle pulse; rx_byte is already valid in the same cycle
- frame_err  out  1  sticky; set on a bad stop bit, cleared by the next good byte or by reset
- parity_err  out  1  one-cycle pulse on a parity mismatch (tied 0 without the macro)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Synchronizer: rx passes through 2 flops to give rxs. All decisions use rxs only.
- Reset: synchronous, active-high. Every register is cleared on the clock edge while reset=1: rx_byte=0, rbyte_ready=0, frame_err=0, parity_err=0, busy=0, state=IDLE, counters=0.
  - Reset overrides any frame in progress; that partial frame is discarded.
  - The synchronizer flops reset to 1.
- Bit-timing counter cnt: counts 0..BAUD_DIV-1. It is cleared on every state change.
- IDLE:
  - rxs==0 -> START, cnt=0.
- START:
  - At cnt==HALF_DIV-1: if rxs==0 -> DATA (bit index=0, cnt=0); else the low pulse was a glitch -> IDLE.
  - A glitch produces no pulse and no error.
- DATA:
  - At each cnt==BAUD_DIV-1: shift sr <= {rxs, sr[7:1]} (LSB first); bit index +1.
  - After the 8th sample -> STOP, or -> PARITY when the macro is enabled.
- STOP:
  - At cnt==BAUD_DIV-1, sample rxs.
  - rxs==1: on the next edge rx_byte<=sr, rbyte_ready=1 for exactly one cycle, frame_err<=0, then -> IDLE.
    - Returning to IDLE mid-stop-bit is deliberate; it allows back-to-back frames.
  - rxs==0: frame_err<=1, rx_byte unchanged, no pulse -> BREAK.
- BREAK:
  - Wait for rxs==1, then -> IDLE. A held-low line (break) never produces a byte.
- Latency: rbyte_ready rises 2 sync cycles + 0.5 + 9 bit periods after the start-bit falling edge on rx (+1 bit period with parity), ±1 clk.
- Back-to-back frames: a start bit that arrives immediately after the stop-bit sample must be caught. IDLE is re-entered before the next falling edge is possible.
- rbyte_ready and parity_err are never high at the same time, and neither stays high for more than 1 cycle.
- rbyte_ready pulses are at least 9*BAUD_DIV cycles apart. This is sufficient for the loader's 2-flop edge detect and its rx_byte latch 2 cycles later.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: PARITY state is inserted between DATA and STOP.
  - At cnt==BAUD_DIV-1, sample rxs as the parity bit and check even parity: ^sr ^ rxs must equal 0.
  - Mismatch: parity_err pulses for 1 cycle at the end of the stop bit instead of rbyte_ready; rx_byte is unchanged; the frame is dropped.
  - A bad stop bit still sets frame_err and takes priority: no parity_err pulse for that frame.
- Undefined: no PARITY state, parity_err is constant 0, and the frame is 10 bits.

Test Plan (BAUD_DIV=16, ideal line timing):
- Reset, rx held high 200 cycles -> all outputs 0, busy=0, no pulses.
- Send 0x2A then 0x2D back-to-back (zero idle gap) -> two single-cycle rbyte_ready pulses.
  - rx_byte=8'h2A at the first pulse and 8'h2D at the second.
  - Pulse spacing = 160 cycles (10 bits × 16).
- rx low for 5 cycles, then high -> busy pulses, returns to IDLE, no rbyte_ready, frame_err=0.
- Send 0x55 with stop bit forced 0 -> frame_err=1, no pulse, rx_byte keeps 0x2D.
  - Hold rx low 100 cycles -> still no pulse.
  - Release, then send 0x41 -> rx_byte=8'h41, pulse, frame_err=0.
- Assert reset for 1 cycle during the 4th data bit of a frame -> all outputs 0 the next cycle.
  - The remainder of the aborted frame must produce no pulse.
  - A following clean frame 0x2A is received correctly.
- With UART_RX_PARITY_EN:
  - 0x2A with parity bit 1 -> accepted.
  - 0x2A with parity bit 0 -> parity_err pulse, no rbyte_ready, rx_byte unchanged.
